// File: rtl/mux8_rr_arbiter.sv
// 8-input round-robin arbiter driving a mux select, with ack-terminated grants and a grant timeout.
// Latency: request to grant one cycle, all outputs registered. Backpressure: a grant is held until ack or TIMEOUT cycles elapse.
module mux8_rr_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       tout_q, tout_d;

    // Returns {found, index}: first set bit scanning p, p+1, ... p+7 mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic       found;
        logic [2:0] win;
        logic [2:0] idx;
        found = 1'b0;
        win   = p;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [2:0] ptr_after;
    logic [3:0] pick_idle;
    logic [3:0] pick_ack;
    logic       cnt_expired;

    assign ptr_after   = sel_q + 3'd1;
    assign pick_idle   = rr_pick(req, ptr_q);
    assign pick_ack    = rr_pick(req, ptr_after);
    assign cnt_expired = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        tout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_idle[3]) begin
                    state_d = GRANT;
                    gnt_d   = 8'b1 << pick_idle[2:0];
                    sel_d   = pick_idle[2:0];
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    gnt_d  = 8'd0;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                // Ack beats the timeout when both land on the same edge.
                if (ack) begin
                    ptr_d = ptr_after;
                    cnt_d = 8'd0;
                    if (pick_ack[3]) begin
                        gnt_d = 8'b1 << pick_ack[2:0];
                        sel_d = pick_ack[2:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 8'd0;
                        busy_d  = 1'b0;
                    end
                end else if (cnt_expired) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                    gnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt         = gnt_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter built with TIMEOUT=4; each scenario continues from the state the previous one left.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       ack;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    mux8_rr_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .gnt         (gnt),
        .sel         (sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 8'hFF;
        ack   = 1'b1;
        tick();
        tick();
        total++;
        if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%h sel=%0d busy=%b terr=%b, want 00/0/0/0",
                     gnt, sel, busy, timeout_err);
        end
        total++;
        if (dut.ptr_q !== 3'd0 || dut.cnt_q !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: got ptr=%0d cnt=%0d, want 0/0", dut.ptr_q, dut.cnt_q);
        end
    endtask

    // req=81 with ack held: grants 0,7,0,7 with no idle gap.
    task automatic test_rotation;
        logic [2:0] exp_sel [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
        logic [7:0] exp_gnt [4] = '{8'h01, 8'h80, 8'h01, 8'h80};
        reset = 1'b0;
        req   = 8'h81;
        ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack = 1'b1;
            total++;
            if (gnt !== exp_gnt[i] || sel !== exp_sel[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL rotation_%0d: got gnt=%h sel=%0d busy=%b, want %h/%0d/1",
                         i, gnt, sel, busy, exp_gnt[i], exp_sel[i]);
            end
        end
        req = 8'h00;
        tick();
        ack = 1'b0;
        total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd7) begin
            bad++;
            $display("FAIL rotation_release: got gnt=%h sel=%0d busy=%b, want 00/7/0", gnt, sel, busy);
        end
    endtask

    task automatic test_single_grant;
        req = 8'h00;
        tick();
        total++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_noreq: got gnt=%h busy=%b, want 00/0", gnt, busy);
        end
        req = 8'h10;
        tick();
        total++;
        if (gnt !== 8'h10 || sel !== 3'd4 || busy !== 1'b1) begin
            bad++;
            $display("FAIL grant4: got gnt=%h sel=%0d busy=%b, want 10/4/1", gnt, sel, busy);
        end
        // Grant must ignore req changes, including withdrawal.
        req = 8'h01;
        tick();
        total++;
        if (gnt !== 8'h10 || sel !== 3'd4) begin
            bad++;
            $display("FAIL grant_hold: got gnt=%h sel=%0d, want 10/4", gnt, sel);
        end
        req = 8'h00;
        ack = 1'b1;
        tick();
        total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd4) begin
            bad++;
            $display("FAIL release4: got gnt=%h sel=%0d busy=%b, want 00/4/0", gnt, sel, busy);
        end
        tick();
        ack = 1'b0;
        total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd4) begin
            bad++;
            $display("FAIL idle_ack_ignored: got gnt=%h sel=%0d busy=%b, want 00/4/0", gnt, sel, busy);
        end
    endtask

    // ptr is 5 here; only req[2] set so index 2 wins and then times out.
    task automatic test_timeout;
        req = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (gnt !== 8'h04 || busy !== 1'b1 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL timeout_hold_%0d: got gnt=%h busy=%b terr=%b, want 04/1/0",
                         i, gnt, busy, timeout_err);
            end
        end
        tick();
        total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout_err !== 1'b1 || dut.ptr_q !== 3'd3) begin
            bad++;
            $display("FAIL timeout_pulse: got gnt=%h busy=%b terr=%b ptr=%0d, want 00/0/1/3",
                     gnt, busy, timeout_err, dut.ptr_q);
        end
        tick();
        total++;
        if (gnt !== 8'h04 || sel !== 3'd2 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_regrant: got gnt=%h sel=%0d terr=%b, want 04/2/0", gnt, sel, timeout_err);
        end
    endtask

    // Grant 2 fresh (cnt=0); ack lands on the edge where cnt==3.
    task automatic test_ack_at_timeout;
        req = 8'h24;
        tick();
        tick();
        tick();
        total++;
        if (gnt !== 8'h04 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL pre_timeout: got gnt=%h terr=%b, want 04/0", gnt, timeout_err);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (gnt !== 8'h20 || sel !== 3'd5 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL ack_wins: got gnt=%h sel=%0d busy=%b terr=%b, want 20/5/1/0",
                     gnt, sel, busy, timeout_err);
        end
    endtask

    task automatic test_reset_mid_grant;
        reset = 1'b1;
        ack   = 1'b1;
        tick();
        total++;
        if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_grant: got gnt=%h sel=%0d busy=%b terr=%b, want 00/0/0/0",
                     gnt, sel, busy, timeout_err);
        end
        reset = 1'b0;
        ack   = 1'b0;
        tick();
        total++;
        if (gnt !== 8'h04 || sel !== 3'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_grant: got gnt=%h sel=%0d busy=%b, want 04/2/1", gnt, sel, busy);
        end
        req = 8'h00;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (busy !== 1'b0 || gnt !== 8'h00) begin
            bad++;
            $display("FAIL post_reset_release: got gnt=%h busy=%b, want 00/0", gnt, busy);
        end
    endtask

    // ptr is 3; grant 7 then ack with everyone requesting wraps to 0.
    task automatic test_wrap;
        req = 8'h80;
        tick();
        total++;
        if (gnt !== 8'h80 || sel !== 3'd7) begin
            bad++;
            $display("FAIL wrap_grant7: got gnt=%h sel=%0d, want 80/7", gnt, sel);
        end
        req = 8'hFF;
        ack = 1'b1;
        tick();
        total++;
        if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wrap_to0: got gnt=%h sel=%0d busy=%b, want 01/0/1", gnt, sel, busy);
        end
        req = 8'h00;
        tick();
        ack = 1'b0;
    endtask

    // ptr is 1; req bits 1,2,4 rotate 1,2,4 then back to 1.
    task automatic test_back_to_back;
        logic [2:0] exp_sel [4] = '{3'd1, 3'd2, 3'd4, 3'd1};
        req = 8'h16;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack = 1'b1;
            total++;
            if (sel !== exp_sel[i] || gnt !== (8'h01 << exp_sel[i]) || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d: got gnt=%h sel=%0d busy=%b, want sel=%0d",
                         i, gnt, sel, busy, exp_sel[i]);
            end
        end
        req = 8'h00;
        tick();
        ack = 1'b0;
        total++;
        if (busy !== 1'b0 || sel !== 3'd1) begin
            bad++;
            $display("FAIL b2b_release: got busy=%b sel=%0d, want 0/1", busy, sel);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        ack   = 1'b0;
        test_reset();
        test_rotation();
        test_single_grant();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_grant();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
